// File: rtl/main_ret_capture.sv
// main_ret_capture: samples main_ret strobes from the main_E kernel into a
// first-word-fall-through FIFO, keeps a saturating result count and a wrapping
// checksum per capture run, and drains the buffered results over ready/valid.
module main_ret_capture #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             cap_en,
  input  logic [CNT_W-1:0] expect_cnt,
  input  logic [DW-1:0]    main_ret,
  input  logic             main_ret_vld,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [CNT_W-1:0] ret_count,
  output logic [DW-1:0]    checksum,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  // FIFO storage and bookkeeping
  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_inc;
  logic [LW-1:0]    level_reg;
  logic [LW-1:0]    level_after_pop;
  logic [DW-1:0]    out_data_reg;
  logic [DW-1:0]    out_data_next;

  // run statistics
  logic [CNT_W-1:0] ret_count_reg;
  logic [CNT_W-1:0] ret_count_inc;
  logic [CNT_W-1:0] expect_reg;
  logic [DW-1:0]    checksum_reg;
  logic             overflow_reg;

  // per-cycle events
  logic             full_w;
  logic             empty_w;
  logic             in_capture;
  logic             pop;
  logic             room;
  logic             push;
  logic             drop;
  logic             count_hit;
  logic             run_start;

  assign full_w     = (level_reg == LW'(DEPTH));
  assign empty_w    = (level_reg == '0);
  assign in_capture = (state_reg == S_CAPTURE);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a
  // push when the consumer takes the head at the same edge.
  assign pop  = !empty_w && out_ready && !clr;
  assign room = !full_w || pop;
  assign push = in_capture && main_ret_vld && room && !clr;
  assign drop = in_capture && main_ret_vld && !room && !clr;

  assign rd_ptr_inc    = rd_ptr_reg + 1'b1;
  assign ret_count_inc = (ret_count_reg == '1) ? ret_count_reg : ret_count_reg + 1'b1;

  // The run ends on the edge of the push that makes the count equal the
  // latched target; a zero target means the run is only ended by cap_en.
  assign count_hit = push && (expect_reg != '0) && (ret_count_inc == expect_reg);

  // Next-state logic for the capture-run bracket; clr overrides everything.
  always_comb begin
    state_next = state_reg;
    run_start  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (cap_en) begin
          state_next = S_CAPTURE;
          run_start  = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (!cap_en || count_hit) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty_w) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!cap_en) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (clr) begin
      state_next = S_IDLE;
      run_start  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next head word: the incoming value when it lands in an otherwise empty
  // FIFO, the following entry after a pop, otherwise the head is unchanged.
  always_comb begin
    level_after_pop = pop ? (level_reg - 1'b1) : level_reg;
    out_data_next   = out_data_reg;
    if (push && (level_after_pop == '0)) begin
      out_data_next = main_ret;
    end else if (pop && (level_after_pop != '0)) begin
      out_data_next = mem[rd_ptr_inc];
    end
  end

  // FIFO array write; no reset so it maps onto RAM.
  always_ff @(posedge CLOCK) begin
    if (push) begin
      mem[wr_ptr_reg] <= main_ret;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      out_data_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      out_data_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      out_data_reg <= out_data_next;
    end
  end

  // Run statistics: cleared when a run starts, held through DRAIN/DONE/IDLE.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      ret_count_reg <= '0;
      checksum_reg  <= '0;
      overflow_reg  <= 1'b0;
      expect_reg    <= '0;
    end else if (clr) begin
      ret_count_reg <= '0;
      checksum_reg  <= '0;
      overflow_reg  <= 1'b0;
      expect_reg    <= '0;
    end else if (run_start) begin
      ret_count_reg <= '0;
      checksum_reg  <= '0;
      overflow_reg  <= 1'b0;
      expect_reg    <= expect_cnt;
    end else begin
      if (push) begin
        ret_count_reg <= ret_count_inc;
        checksum_reg  <= checksum_reg + main_ret;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = !empty_w;
  assign level     = level_reg;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = overflow_reg;
  assign ret_count = ret_count_reg;
  assign checksum  = checksum_reg;
  assign done      = (state_reg == S_DONE);

endmodule

// File: tb/tb_main_ret_capture.sv
// Directed testbench for main_ret_capture: one task per scenario, each with
// hand-computed expectations checked inline.
module tb_main_ret_capture;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             CLOCK = 1'b0;
  logic             RESET;
  logic             clr;
  logic             cap_en;
  logic [CNT_W-1:0] expect_cnt;
  logic [DW-1:0]    main_ret;
  logic             main_ret_vld;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [CNT_W-1:0] ret_count;
  logic [DW-1:0]    checksum;
  logic             done;

  int checks   = 0;
  int failures = 0;

  main_ret_capture #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .clr(clr), .cap_en(cap_en),
    .expect_cnt(expect_cnt), .main_ret(main_ret), .main_ret_vld(main_ret_vld),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .ret_count(ret_count), .checksum(checksum), .done(done)
  );

  always #5 CLOCK = ~CLOCK;

  // advance one clock edge and settle 1 time unit after it
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0; clr = 1'b0; cap_en = 1'b0; expect_cnt = '0;
    main_ret = '0; main_ret_vld = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (full !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL reset_flags: got full=%b empty=%b expected 0/1", full, empty); end
    checks++; if (overflow !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_ovf_done: got %b/%b expected 0/0", overflow, done); end
    checks++; if (ret_count !== 16'd0 || checksum !== 32'h0) begin failures++; $display("FAIL reset_stats: got %0d/%h expected 0/0", ret_count, checksum); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] v [4];
    v[0] = 32'h11; v[1] = 32'h22; v[2] = 32'h33; v[3] = 32'h44;
    do_reset();
    expect_cnt = 16'd4; cap_en = 1'b1; out_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      main_ret = v[i]; main_ret_vld = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== v[i]) begin failures++; $display("FAIL basic_out%0d: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, v[i]); end
    end
    main_ret = 32'h55;
    step();
    main_ret_vld = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_fifth_ignored: got out_valid=%b expected 0", out_valid); end
    checks++; if (ret_count !== 16'd4) begin failures++; $display("FAIL basic_count: got %0d expected 4", ret_count); end
    checks++; if (checksum !== 32'hAA) begin failures++; $display("FAIL basic_checksum: got %h expected aa", checksum); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_early: got %b expected 0", done); end
    step();
    checks++; if (done !== 1'b1 || level !== 5'd0) begin failures++; $display("FAIL basic_done: got done=%b level=%0d expected 1/0", done, level); end
    cap_en = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_idle: got done=%b expected 0", done); end
  endtask

  task automatic test_overflow();
    do_reset();
    expect_cnt = 16'd0; cap_en = 1'b1; out_ready = 1'b0;
    step();
    for (int i = 1; i <= 18; i++) begin
      main_ret = DW'(i); main_ret_vld = 1'b1;
      step();
      if (i == 16) begin
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full16: got full=%b ovf=%b expected 1/0", full, overflow); end
      end
      if (i == 17) begin
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      end
    end
    main_ret_vld = 1'b0;
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL ovf_level: got %0d expected 16", level); end
    checks++; if (ret_count !== 16'd16) begin failures++; $display("FAIL ovf_count: got %0d expected 16", ret_count); end
    checks++; if (checksum !== 32'd136) begin failures++; $display("FAIL ovf_checksum: got %0d expected 136", checksum); end
    cap_en = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin failures++; $display("FAIL ovf_drain%0d: got valid=%b data=%0d expected 1/%0d", i, out_valid, out_data, i); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained: got out_valid=%b expected 0", out_valid); end
    step();
    checks++; if (done !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_done: got done=%b ovf=%b expected 1/1", done, overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    expect_cnt = 16'd0; cap_en = 1'b1; out_ready = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      main_ret = 32'hA0 + DW'(i); main_ret_vld = 1'b1;
      step();
    end
    checks++; if (full !== 1'b1 || out_data !== 32'hA0) begin failures++; $display("FAIL fp_full: got full=%b head=%h expected 1/a0", full, out_data); end
    main_ret = 32'h55; main_ret_vld = 1'b1; out_ready = 1'b1;
    step();
    main_ret_vld = 1'b0;
    checks++; if (level !== 5'd16 || overflow !== 1'b0) begin failures++; $display("FAIL fp_push_pop: got level=%0d ovf=%b expected 16/0", level, overflow); end
    checks++; if (ret_count !== 16'd17) begin failures++; $display("FAIL fp_count: got %0d expected 17", ret_count); end
    for (int i = 1; i <= 15; i++) begin
      checks++; if (out_data !== 32'hA0 + DW'(i)) begin failures++; $display("FAIL fp_seq%0d: got %h expected %h", i, out_data, 32'hA0 + i); end
      step();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin failures++; $display("FAIL fp_last: got valid=%b data=%h expected 1/55", out_valid, out_data); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model_sum;
    logic [DW-1:0] v;
    logic [DW-1:0] want;
    int sent;
    int cycles;
    do_reset();
    expect_cnt = 16'd0; cap_en = 1'b1;
    step();
    sent = 0; cycles = 0; model_sum = '0;
    while ((sent < 100 || exp_q.size() != 0 || out_valid) && cycles < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL wrap_extra: got %h expected no data", out_data);
        end else begin
          want = exp_q.pop_front();
          if (out_data !== want) begin failures++; $display("FAIL wrap_order: got %h expected %h", out_data, want); end
        end
      end
      if (sent < 100 && !full) begin
        v = (sent < 10) ? (32'hFFFF_FFF6 + DW'(sent)) : (32'h9E37_79B9 * DW'(sent));
        main_ret = v; main_ret_vld = 1'b1;
        exp_q.push_back(v);
        model_sum = model_sum + v;
        sent++;
      end else begin
        main_ret_vld = 1'b0;
      end
      step();
      cycles++;
    end
    main_ret_vld = 1'b0;
    checks++; if (cycles >= 2000) begin failures++; $display("FAIL wrap_timeout: got %0d cycles expected < 2000", cycles); end
    checks++; if (ret_count !== 16'd100) begin failures++; $display("FAIL wrap_count: got %0d expected 100", ret_count); end
    checks++; if (checksum !== model_sum) begin failures++; $display("FAIL wrap_checksum: got %h expected %h", checksum, model_sum); end
    checks++; if (overflow !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL wrap_loss: got ovf=%b left=%0d expected 0/0", overflow, exp_q.size()); end
  endtask

  task automatic test_cap_drop();
    do_reset();
    expect_cnt = 16'd0; cap_en = 1'b1; out_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      main_ret = 32'h70 + DW'(i); main_ret_vld = 1'b1;
      step();
    end
    main_ret_vld = 1'b0; cap_en = 1'b0;
    step();
    main_ret = 32'h99; main_ret_vld = 1'b1;
    step();
    step();
    main_ret_vld = 1'b0;
    checks++; if (level !== 5'd3 || overflow !== 1'b0) begin failures++; $display("FAIL drop_ignored: got level=%0d ovf=%b expected 3/0", level, overflow); end
    checks++; if (ret_count !== 16'd3 || checksum !== 32'h153) begin failures++; $display("FAIL drop_stats: got %0d/%h expected 3/153", ret_count, checksum); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_data !== 32'h70 + DW'(i)) begin failures++; $display("FAIL drop_drain%0d: got %h expected %h", i, out_data, 32'h70 + i); end
      step();
    end
    checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL drop_pre_done: got valid=%b done=%b expected 0/0", out_valid, done); end
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL drop_done: got %b expected 1", done); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL drop_idle: got %b expected 0", done); end
  endtask

  task automatic fill_five();
    do_reset();
    expect_cnt = 16'd0; cap_en = 1'b1; out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      main_ret = 32'hC0 + DW'(i); main_ret_vld = 1'b1;
      step();
    end
    main_ret_vld = 1'b0;
  endtask

  task automatic test_async_reset();
    fill_five();
    checks++; if (level !== 5'd5) begin failures++; $display("FAIL ar_level5: got %0d expected 5", level); end
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL ar_fifo: got level=%0d empty=%b full=%b valid=%b expected 0/1/0/0", level, empty, full, out_valid); end
    checks++; if (out_data !== 32'h0 || ret_count !== 16'd0 || checksum !== 32'h0) begin failures++; $display("FAIL ar_stats: got data=%h cnt=%0d sum=%h expected 0/0/0", out_data, ret_count, checksum); end
    checks++; if (overflow !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ar_flags: got ovf=%b done=%b expected 0/0", overflow, done); end
    step();
    RESET = 1'b1;
  endtask

  task automatic test_clr();
    fill_five();
    checks++; if (level !== 5'd5 || ret_count !== 16'd5) begin failures++; $display("FAIL clr_pre: got level=%0d cnt=%0d expected 5/5", level, ret_count); end
    clr = 1'b1; main_ret = 32'h33; main_ret_vld = 1'b1; out_ready = 1'b1;
    step();
    clr = 1'b0; main_ret_vld = 1'b0; cap_en = 1'b0;
    checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL clr_fifo: got level=%0d empty=%b full=%b valid=%b expected 0/1/0/0", level, empty, full, out_valid); end
    checks++; if (out_data !== 32'h0 || ret_count !== 16'd0 || checksum !== 32'h0) begin failures++; $display("FAIL clr_stats: got data=%h cnt=%0d sum=%h expected 0/0/0", out_data, ret_count, checksum); end
    checks++; if (overflow !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL clr_flags: got ovf=%b done=%b expected 0/0", overflow, done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_cap_drop();
    test_async_reset();
    test_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/main_ret_capture.md
# main_ret_capture

Downstream result stage for the synthesized `main_E` kernel. It samples each `main_ret` value as the kernel publishes it and buffers the values in a first-word-fall-through FIFO. It keeps a count and a wrapping checksum of accepted results, then drains them over a ready/valid port to the host/logging side. A small state machine brackets one capture run and flags completion.

## Interface
Parameters:
- `DW`, 32, width of `main_ret` and of FIFO words
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of result counter and `expect_cnt`

Ports:
- `CLOCK`  in  1  single clock; all state updates on its rising edge
- `RESET`  in  1  asynchronous, active-low reset
- `clr`  in  1  synchronous clear; returns to IDLE and clears all state as reset does
- `cap_en`  in  1  capture enable, level
- `expect_cnt`  in  CNT_W  results expected per run; 0 = unlimited; sampled on IDLE→CAPTURE
- `main_ret`  in  DW  kernel return value
- `main_ret_vld`  in  1  one-cycle strobe; `main_ret` is valid this cycle
- `out_data`  out  DW  FIFO head word
- `out_valid`  out  1  `out_data` holds a valid entry
- `out_ready`  in  1  consumer accepts the head this cycle
- `level`  out  log2(DEPTH)+1  FIFO occupancy
- `full`  out  1  level == DEPTH
- `empty`  out  1  level == 0
- `overflow`  out  1  sticky; a strobe was dropped because the FIFO was full
- `ret_count`  out  CNT_W  accepted results this run; saturates at all-ones
- `checksum`  out  DW  sum of accepted values, mod 2^DW
- `done`  out  1  run complete and FIFO drained

## Operation
- States:
  - IDLE → CAPTURE when `cap_en`=1. Latches `expect_cnt`.
  - CAPTURE → DRAIN when `cap_en`=0, or when the latched expect ≠0 and `ret_count` reaches it after a push.
  - DRAIN → DONE when `empty`=1.
  - DONE → IDLE when `cap_en`=0.
  - Any state → IDLE on `clr`. `clr` has priority over every other event.
- Push occurs only in CAPTURE when `main_ret_vld`=1 and the FIFO has room. "Room" means `!full`, or `full` with a pop in the same cycle.
- On push: write `main_ret` at the write pointer, increment `ret_count` (saturating), and add `main_ret` to `checksum` (wrapping).
- A strobe in CAPTURE with no room is dropped: sets `overflow`; `ret_count` and `checksum` are unchanged.
- Strobes in IDLE, DRAIN or DONE are ignored. They do not set `overflow`.
- Pop occurs when `out_valid` && `out_ready`, in any state except during `clr`. Pops continue in IDLE/DONE if data remains.
- Simultaneous push and pop: `level` is unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `ret_count`, `checksum` and `overflow` hold their values in DONE and IDLE until `clr` or reset. IDLE→CAPTURE clears `ret_count`, `checksum` and `overflow`; FIFO contents are kept.

## Timing
- Reset / `clr` values:
  - state = IDLE
  - `out_data` = 0, `out_valid` = 0, `level` = 0, `full` = 0, `empty` = 1
  - `overflow` = 0, `ret_count` = 0, `checksum` = 0, `done` = 0
  - pointers = 0
- Reset deassertion has no special synchronization requirement beyond async assert.
- Push latency: a strobe sampled at edge k gives `out_valid`=1 and `out_data`=value in the cycle after edge k. There is no same-cycle bypass.
- Pop: the head advances at the edge where `out_valid`&&`out_ready`. The next word, or `out_valid`=0, is visible in the following cycle.
- `level`, `full`, `empty`, `ret_count` and `checksum` are registered and update at the same edge as the push/pop.
- `done` is registered; it is 1 exactly while in DONE. DRAIN→DONE occurs at the edge after `empty` is observed 1. When DRAIN is entered with an already empty FIFO, this is one cycle after entering DRAIN.
- The transition to DRAIN on reaching the count takes effect at the edge of the final push. A strobe in the next cycle is ignored.
- `out_data` holds its last value when `out_valid`=0. The bench must not check it then.

## Test plan
- Basic run: reset, `expect_cnt`=4, `cap_en`=1, `out_ready`=1, strobes of 0x11, 0x22, 0x33, 0x44 on consecutive cycles → out sequence 0x11, 0x22, 0x33, 0x44, each one cycle after its strobe. `ret_count`=4, `checksum`=0xAA, `done`=1 once drained. A fifth strobe is ignored.
- Overflow: DEPTH=16, `out_ready`=0, `expect_cnt`=0, 18 strobes of values 1..18 → `full`=1 after the 16th, `overflow`=1, `ret_count`=16, `checksum`=136. Draining yields 1..16.
- Full with simultaneous pop: fill to 16, then strobe 0x55 with `out_ready`=1 in the same cycle → push accepted, `level` stays 16, `overflow`=0. 0x55 emerges after 15 further pops.
- Wrap-around and backpressure: random `out_ready` (50%), 100 strobes with unlimited count → output order equals input order, no loss. `ret_count`=100; `checksum` matches the model mod 2^32, including carry wrap with values near 0xFFFFFFFF.
- `cap_en` drop: 3 strobes with `out_ready`=0, then `cap_en`=0 → DRAIN. Further strobes are ignored. Raising `out_ready` empties the FIFO → `done`=1, then `done`=0 back in IDLE.
- Reset/clear mid-run: assert `RESET`=0 asynchronously with `level`=5 mid-cycle → all outputs take reset values immediately. Repeat with `clr`=1 → identical values at the next edge.
